// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode 7-segment driver for a packed-BCD value, with
// per-slot anode-off guard window, leading-zero blanking, minus sign and frame-boundary commit.
module sevenseg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_PERIOD    = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    neg_in,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_done
);
    localparam int CW = $clog2(SCAN_PERIOD);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_PERIOD - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_MINUS = 7'h40;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DW-1:0] sh_digits, act_digits;
    logic          sh_neg, act_neg;
    logic          sh_blz, act_blz;

    assign frame_done = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Shadow takes loads at any time; the active copy only moves at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            sh_digits  <= '0;
            sh_neg     <= 1'b0;
            sh_blz     <= 1'b1;
            act_digits <= '0;
            act_neg    <= 1'b0;
            act_blz    <= 1'b1;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (load) begin
                sh_digits <= digits_in;
                sh_neg    <= neg_in;
                sh_blz    <= blank_lz;
            end
            if (frame_done) begin
                act_digits <= load ? digits_in : sh_digits;
                act_neg    <= load ? neg_in    : sh_neg;
                act_blz    <= load ? blank_lz  : sh_blz;
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    logic [IW-1:0]         msd;
    logic                  nonzero;
    logic [6:0]            seg_hi;
    logic [NUM_DIGITS-1:0] an_hi;
    logic                  lit;

    always_comb begin
        msd     = '0;
        nonzero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act_digits[4*i +: 4] != 4'd0) begin
                msd     = IW'(i);
                nonzero = 1'b1;
            end
        end

        seg_hi = glyph(act_digits[{idx, 2'b00} +: 4]);
        // With no nonzero digit msd stays 0, so only position 0 survives blanking.
        if (act_blz && (idx > msd))
            seg_hi = 7'h00;
        if (act_neg && nonzero) begin
            if (act_blz && (msd != IDX_LAST)) begin
                if ({1'b0, idx} == ({1'b0, msd} + (IW+1)'(1)))
                    seg_hi = SEG_MINUS;
            end else if (idx == IDX_LAST) begin
                seg_hi = SEG_MINUS;
            end
        end

        lit   = (cnt >= BLANK_END);
        an_hi = '0;
        if (lit)
            an_hi[idx] = 1'b1;
        else
            seg_hi = 7'h00;

        if (SEG_ACTIVE_LOW != 0) begin
            an  = ~an_hi;
            seg = ~seg_hi;
        end else begin
            an  = an_hi;
            seg = seg_hi;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: a cycle-count display model compared against an/seg/frame_done
// every cycle, plus directed literal checks of the documented display cases.
module tb_sevenseg_scan;
    localparam int N     = 4;
    localparam int SP    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * SP;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [15:0]   digits_in;
    logic          neg_in;
    logic          blank_lz;
    logic [N-1:0]  an;
    logic [6:0]    seg;
    logic          frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: cycles since reset release, shadow and displayed values
    int          m_t;
    logic [15:0] m_sd, m_ad;
    logic        m_sn, m_an, m_sb, m_ab;

    logic [6:0] glyph_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    sevenseg_scan #(
        .NUM_DIGITS(N), .SCAN_PERIOD(SP), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
        .neg_in(neg_in), .blank_lz(blank_lz), .an(an), .seg(seg),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0d)", tag, got, exp, m_t);
    endtask

    function automatic logic [6:0] shown_char(input int pos);
        logic [6:0] chars [N];
        int top = -1;
        int sp;
        for (int i = 0; i < N; i++) begin
            int d = int'(m_ad[4*i +: 4]);
            if (d != 0) top = i;
            chars[i] = (d < 10) ? glyph_tbl[d] : 7'h00;
        end
        if (m_ab)
            for (int i = 1; i < N; i++)
                if (i > top) chars[i] = 7'h00;
        if (m_an && top >= 0) begin
            sp = (m_ab && top < N - 1) ? top + 1 : N - 1;
            chars[sp] = 7'h40;
        end
        return chars[pos];
    endfunction

    function automatic logic [N-1:0] exp_an();
        int pos  = m_t % SP;
        int slot = (m_t / SP) % N;
        logic [N-1:0] one_hot = '0;
        if (pos < BC) return '1;
        one_hot[slot] = 1'b1;
        return ~one_hot;
    endfunction

    function automatic logic [6:0] exp_seg();
        int pos  = m_t % SP;
        int slot = (m_t / SP) % N;
        if (pos < BC) return 7'h7F;
        return ~shown_char(slot);
    endfunction

    task automatic reset_model();
        m_t  = 0;
        m_sd = '0; m_ad = '0;
        m_sn = 1'b0; m_an = 1'b0;
        m_sb = 1'b1; m_ab = 1'b1;
    endtask

    // Called at a negedge: compare, drive the next inputs, advance the model one edge.
    task automatic cycle(input logic ld, input logic [15:0] d, input logic ng, input logic bz);
        logic fd;
        check("an", 32'(an), 32'(exp_an()));
        check("seg", 32'(seg), 32'(exp_seg()));
        fd = ((m_t % FRAME) == FRAME - 1);
        check("frame_done", 32'(frame_done), 32'(fd));
        load = ld; digits_in = d; neg_in = ng; blank_lz = bz;
        if (fd) begin
            m_ad = ld ? d  : m_sd;
            m_an = ld ? ng : m_sn;
            m_ab = ld ? bz : m_sb;
        end
        if (ld) begin
            m_sd = d; m_sn = ng; m_sb = bz;
        end
        m_t++;
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic idle();
        cycle(1'b0, rand_digits(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic goto(input int slot, input int pos);
        int guard = 0;
        while ((m_t % FRAME) != slot * SP + pos && guard < 2 * FRAME) begin
            idle();
            guard++;
        end
    endtask

    task automatic expect_at(input string tag, input int slot, input int pos,
                             input logic [N-1:0] an_e, input logic [6:0] seg_e);
        goto(slot, pos);
        check({tag, "_an"}, 32'(an), 32'(an_e));
        check({tag, "_seg"}, 32'(seg), 32'(seg_e));
    endtask

    // Load now, then run until the value has been committed and a new frame begins.
    task automatic show(input logic [15:0] d, input logic ng, input logic bz);
        cycle(1'b1, d, ng, bz);
        goto(0, 0);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; digits_in = '0; neg_in = 1'b0; blank_lz = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'(4'hF));
        check("rst_seg", 32'(seg), 32'(7'h7F));
        check("rst_fd", 32'(frame_done), 32'(0));
        rst_n = 1'b1;

        // Power-up display "   0" with guard window at each slot start
        expect_at("t1_guard", 0, 1, 4'hF, 7'h7F);
        expect_at("t1_s0", 0, 2, 4'b1110, 7'h40);
        expect_at("t1_s1", 1, 2, 4'b1101, 7'h7F);
        expect_at("t1_s3", 3, 7, 4'b0111, 7'h7F);

        // Mid-frame load must not disturb the current frame
        goto(0, 5);
        cycle(1'b1, 16'h1234, 1'b0, 1'b1);
        expect_at("t2_old", 1, 3, 4'b1101, 7'h7F);
        goto(0, 0);
        expect_at("t2_s0", 0, 4, 4'b1110, 7'h19);
        expect_at("t2_s1", 1, 4, 4'b1101, 7'h30);
        expect_at("t2_s2", 2, 4, 4'b1011, 7'h24);
        expect_at("t2_s3", 3, 4, 4'b0111, 7'h79);

        show(16'h0042, 1'b0, 1'b1);
        expect_at("t3_s0", 0, 3, 4'b1110, 7'h24);
        expect_at("t3_s1", 1, 3, 4'b1101, 7'h19);
        expect_at("t3_s2", 2, 3, 4'b1011, 7'h7F);
        expect_at("t3_s3", 3, 3, 4'b0111, 7'h7F);
        show(16'h0042, 1'b0, 1'b0);
        expect_at("t3_nolz_s2", 2, 3, 4'b1011, 7'h40);
        expect_at("t3_nolz_s3", 3, 3, 4'b0111, 7'h40);

        show(16'h0042, 1'b1, 1'b1);
        expect_at("t4_minus", 2, 6, 4'b1011, 7'h3F);
        expect_at("t4_above", 3, 6, 4'b0111, 7'h7F);
        show(16'h0000, 1'b1, 1'b1);
        expect_at("t4_negz_s0", 0, 6, 4'b1110, 7'h40);
        expect_at("t4_negz_s1", 1, 6, 4'b1101, 7'h7F);
        show(16'h1234, 1'b1, 1'b0);
        expect_at("t4_fix_s0", 0, 5, 4'b1110, 7'h19);
        expect_at("t4_fix_s1", 1, 5, 4'b1101, 7'h30);
        expect_at("t4_fix_s2", 2, 5, 4'b1011, 7'h24);
        expect_at("t4_fix_s3", 3, 5, 4'b0111, 7'h3F);

        // Load coincident with frame_done goes straight into the next frame
        goto(3, 7);
        check("t5_fd_high", 32'(frame_done), 32'(1));
        cycle(1'b1, 16'h00A5, 1'b0, 1'b1);
        check("t5_fd_low", 32'(frame_done), 32'(0));
        expect_at("t5_s0", 0, 2, 4'b1110, 7'h12);
        expect_at("t5_hex", 1, 2, 4'b1101, 7'h7F);

        // Randomized traffic, model compared every cycle
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)
                cycle(1'b1, rand_digits(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                idle();
        end

        // Asynchronous reset mid-slot drops pending shadow contents
        show(16'h0077, 1'b0, 1'b1);
        goto(1, 3);
        cycle(1'b1, 16'h0999, 1'b0, 1'b1);
        goto(2, 4);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_an", 32'(an), 32'(4'hF));
        check("t6_async_seg", 32'(seg), 32'(7'h7F));
        load = 1'b0;
        @(negedge clk);
        check("t6_hold_an", 32'(an), 32'(4'hF));
        rst_n = 1'b1;
        reset_model();
        expect_at("t6_guard", 0, 1, 4'hF, 7'h7F);
        expect_at("t6_s0", 0, 2, 4'b1110, 7'h40);
        expect_at("t6_s1", 1, 4, 4'b1101, 7'h7F);
        goto(0, 0);
        expect_at("t6_after", 0, 4, 4'b1110, 7'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
